// File: rtl/st_packet_channel_arbiter_pkg.sv
// Shared types and helpers for the packet channel arbiter and its priority picker.
package st_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index width for n ports; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  localparam int unsigned NUM_IN = 4;
  localparam int unsigned IDX_W  = clog2(NUM_IN);

endpackage

// File: rtl/st_packet_channel_arbiter_picker.sv
// Round-robin priority picker: first requester strictly after ptr, searching upward with wrap.
module rr_priority_picker
  import st_arb_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);

  always_comb begin
    int unsigned p;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    p         = 0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      p = (32'(ptr) + k) % NUM_IN;
      if (!any && req[SEL_W'(p)]) begin
        any               = 1'b1;
        grant[SEL_W'(p)]  = 1'b1;
        grant_idx         = SEL_W'(p);
      end
    end
  end

endmodule

// File: rtl/st_packet_channel_arbiter.sv
// Packet-level round-robin merge of NUM_IN Avalon-ST sources onto one channelized stream.
module st_packet_channel_arbiter
  import st_arb_pkg::*;
#(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHANNEL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        port_enable,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic                     protocol_err
);

  localparam int unsigned SEL_W = clog2(NUM_IN);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   rr_ptr, lock_idx;
  logic [SEL_W-1:0]   win_idx, sel_idx;
  logic [NUM_IN-1:0]  win_grant;
  logic               win_any;
  logic               slot_free_c;
  logic               accept_c;
  logic               err_c;
  logic               sel_sop, sel_eop;
  logic [DATA_W-1:0]  sel_data;
  logic [DATA_W-1:0]  data_arr [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_split
    assign data_arr[g] = in_data[g*DATA_W +: DATA_W];
  end

  rr_priority_picker #(.NUM_IN(NUM_IN)) u_picker (
    .req       (in_valid & port_enable),
    .ptr       (rr_ptr),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign slot_free_c = !out_valid || out_ready;
  assign sel_idx     = (state == LOCKED) ? lock_idx : win_idx;
  assign sel_sop     = in_startofpacket[sel_idx];
  assign sel_eop     = in_endofpacket[sel_idx];
  assign sel_data    = data_arr[sel_idx];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, per-port ready and beat acceptance
  always_comb begin
    state_nxt = state;
    in_ready  = '0;
    accept_c  = 1'b0;
    err_c     = 1'b0;
    case (state)
      IDLE: begin
        if (slot_free_c) in_ready = win_grant;
        accept_c = win_any && slot_free_c;
        if (accept_c) begin
          err_c = !sel_sop;
          if (!sel_eop) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        in_ready[lock_idx] = slot_free_c;
        accept_c = slot_free_c && in_valid[lock_idx];
        if (accept_c) begin
          err_c = sel_sop;
          if (sel_eop) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration pointer and packet owner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= SEL_W'(NUM_IN - 1);
      lock_idx <= '0;
    end else if (accept_c && state == IDLE) begin
      rr_ptr <= win_idx;
      if (!sel_eop) lock_idx <= win_idx;
    end
  end

  // Single-slot output register and error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      protocol_err      <= 1'b0;
    end else begin
      protocol_err <= err_c;
      if (accept_c) begin
        out_valid         <= 1'b1;
        out_data          <= sel_data;
        out_channel       <= CHANNEL_W'(sel_idx);
        out_startofpacket <= sel_sop;
        out_endofpacket   <= sel_eop;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_st_packet_channel_arbiter.sv
// Bench for st_packet_channel_arbiter: directed scenarios plus random traffic against a port-queue model.
module tb_st_packet_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  port_enable, in_valid, in_ready, in_startofpacket, in_endofpacket;
  logic [N*DW-1:0] in_data;
  logic          out_valid, out_ready, out_startofpacket, out_endofpacket, protocol_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_channel;

  st_packet_channel_arbiter #(.NUM_IN(N), .DATA_W(DW), .CHANNEL_W(CW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .port_enable       (port_enable),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  beat_t      src_q [N][$];
  logic [N-1:0] gate;
  int         passed = 0;
  int         total  = 0;

  // Reference: who owns the output, who was served last, and the single output slot
  bit         m_locked;
  int         m_owner, m_last, m_ch;
  bit         m_ov, m_err;
  beat_t      m_beat;

  int         log_ch [$];
  beat_t      log_b [$];
  int         err_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    m_locked = 1'b0; m_owner = 0; m_last = N - 1; m_ch = 0;
    m_ov = 1'b0; m_err = 1'b0; m_beat = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i]           = gate[i];
        in_data[i*DW +: DW]   = src_q[i][0].d;
        in_startofpacket[i]   = src_q[i][0].sop;
        in_endofpacket[i]     = src_q[i][0].eop;
      end else begin
        in_valid[i]           = 1'b0;
        in_data[i*DW +: DW]   = '0;
        in_startofpacket[i]   = 1'b0;
        in_endofpacket[i]     = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int port, input int len, input logic [7:0] base, input bit bad);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.d   = base + 8'(k);
      b.sop = (k == 0) && !bad;
      b.eop = (k == len - 1);
      src_q[port].push_back(b);
    end
  endtask

  // One clock: predict ready, clock, then compare the registered outputs
  task automatic step();
    int    chosen;
    bit    slot, acc;
    logic [N-1:0] exp_ready;
    beat_t b;
    drive();
    #1;
    chosen = -1;
    if (m_locked) chosen = m_owner;
    else
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (chosen < 0 && in_valid[p] && port_enable[p]) chosen = p;
      end
    slot = !m_ov || out_ready;
    exp_ready = '0;
    if (chosen >= 0) exp_ready[chosen] = slot;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = (chosen >= 0) && slot && in_valid[chosen];
    if (out_valid && out_ready) begin
      log_ch.push_back(int'(out_channel));
      log_b.push_back('{d: out_data, sop: out_startofpacket, eop: out_endofpacket});
    end
    @(posedge clk);
    #1;
    if (acc) begin
      b      = src_q[chosen].pop_front();
      m_err  = m_locked ? b.sop : !b.sop;
      m_ov   = 1'b1;
      m_beat = b;
      m_ch   = chosen;
      if (!m_locked) begin
        m_last = chosen;
        if (!b.eop) begin m_locked = 1'b1; m_owner = chosen; end
      end else if (b.eop) m_locked = 1'b0;
    end else begin
      m_err = 1'b0;
      if (out_ready) m_ov = 1'b0;
    end
    if (protocol_err) err_seen++;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("protocol_err", 32'(protocol_err), 32'(m_err));
    if (m_ov)
      check("out_beat", {out_channel, out_data, out_startofpacket, out_endofpacket},
            {8'(m_ch), m_beat.d, m_beat.sop, m_beat.eop});
  endtask

  task automatic check_log(input string tag, input int n, input int ch [8],
                           input logic [7:0] d [8], input logic [7:0] eop_mask);
    check({tag, "_count"}, 32'(log_ch.size()), 32'(n));
    for (int i = 0; i < n && i < log_ch.size(); i++) begin
      check({tag, "_ch"}, 32'(log_ch[i]), 32'(ch[i]));
      check({tag, "_data"}, 32'(log_b[i].d), 32'(d[i]));
      check({tag, "_eop"}, 32'(log_b[i].eop), 32'(eop_mask[i]));
    end
    log_ch.delete();
    log_b.delete();
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  initial begin
    int left;
    reset_n = 1'b0; out_ready = 1'b1; port_enable = '1; gate = '1;
    in_valid = '0; in_data = '0; in_startofpacket = '0; in_endofpacket = '0;
    err_seen = 0;
    reset_model();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fields", {out_channel, out_data, out_startofpacket, out_endofpacket}, 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    repeat (3) step();

    // Round-robin over single-beat packets
    for (int i = 0; i < N; i++) push_pkt(i, 1, 8'hA0 + 8'(i), 1'b0);
    repeat (6) step();
    check_log("rr", 4, '{0, 1, 2, 3, 0, 0, 0, 0},
              '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 0, 0, 0, 0}, 8'h0F);

    // Packet lock: port 0 waits behind a 3-beat packet from port 1
    src_q[1].push_back('{d: 8'h11, sop: 1'b1, eop: 1'b0});
    src_q[1].push_back('{d: 8'h22, sop: 1'b0, eop: 1'b0});
    src_q[1].push_back('{d: 8'h33, sop: 1'b0, eop: 1'b1});
    step();
    push_pkt(0, 1, 8'h44, 1'b0);
    repeat (6) step();
    check_log("lock", 4, '{1, 1, 1, 0, 0, 0, 0, 0},
              '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}, 8'h0C);

    // Backpressure mid-packet
    push_pkt(2, 4, 8'h51, 1'b0);
    repeat (2) step();
    out_ready = 1'b0;
    repeat (5) begin
      step();
      check("bp_hold_data", 32'(out_data), 32'h52);
    end
    out_ready = 1'b1;
    repeat (5) step();
    check_log("bp", 4, '{2, 2, 2, 2, 0, 0, 0, 0},
              '{8'h51, 8'h52, 8'h53, 8'h54, 0, 0, 0, 0}, 8'h08);

    // Enable mask: only ports 0 and 2 may win
    port_enable = 4'b0101;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) push_pkt(i, 1, 8'h60 + 8'(i * 2 + j), 1'b0);
    repeat (6) step();
    check_log("mask", 4, '{0, 2, 0, 2, 0, 0, 0, 0},
              '{8'h60, 8'h64, 8'h61, 8'h65, 0, 0, 0, 0}, 8'h0F);
    push_pkt(2, 3, 8'h70, 1'b0);
    step();
    port_enable = 4'b0001;
    repeat (4) step();
    check_log("mask_lock", 3, '{2, 2, 2, 0, 0, 0, 0, 0},
              '{8'h70, 8'h71, 8'h72, 0, 0, 0, 0, 0}, 8'h04);
    port_enable = '1;
    repeat (8) step();
    check("mask_drained", 32'(src_q[1].size() + src_q[3].size()), 32'd0);
    log_ch.delete(); log_b.delete();

    // Missing SOP in IDLE, then a stray SOP inside a packet
    err_seen = 0;
    push_pkt(3, 1, 8'h77, 1'b1);
    step();
    check("err_pulse", 32'(protocol_err), 32'd1);
    step();
    check("err_clear", 32'(protocol_err), 32'd0);
    src_q[0].push_back('{d: 8'h78, sop: 1'b1, eop: 1'b0});
    src_q[0].push_back('{d: 8'h79, sop: 1'b1, eop: 1'b1});
    repeat (4) step();
    check("err_count", 32'(err_seen), 32'd2);

    // Reset mid-packet drops the partial packet
    push_pkt(1, 4, 8'h81, 1'b0);
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err", 32'(protocol_err), 32'd0);
    flush();
    drive();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    log_ch.delete(); log_b.delete();
    step();
    push_pkt(2, 1, 8'h90, 1'b0);
    repeat (3) step();
    check_log("post_rst", 1, '{2, 0, 0, 0, 0, 0, 0, 0},
              '{8'h90, 0, 0, 0, 0, 0, 0, 0}, 8'h01);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 6 && $urandom_range(0, 3) == 0)
          push_pkt(i, int'($urandom_range(1, 4)), 8'($urandom), $urandom_range(0, 15) == 0);
      gate      = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) port_enable = 4'($urandom);
      step();
    end

    // Drain everything with a bounded budget
    gate = '1; port_enable = '1; out_ready = 1'b1;
    left = 0;
    for (int i = 0; i < N; i++) left += src_q[i].size();
    for (int c = 0; c < 200 && left > 0; c++) begin
      step();
      left = 0;
      for (int i = 0; i < N; i++) left += src_q[i].size();
    end
    check("drain_empty", 32'(left), 32'd0);
    repeat (2) step();
    check("final_idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
